mem_port_loader: RTL and testbench

MEM_PORT_LOADER -- requirements
Module: mem_port_loader

---
 rtl/mem_port_loader.sv | 202 ++++++++++++++++++++
 tb/tb_mem_port_loader.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_loader.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_loader
// Description : Byte-stream command loader. Decodes framed write (0x57) and
//               read (0x52) commands arriving on an rx byte strobe, drives a
//               64-bit masked memory write port or read port, and returns a
//               response on a ready/valid tx byte stream.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_loader #(
  parameter int ADDR_W  = 25,
  parameter int TIMEOUT = 50000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              W0_en,
  output logic [ADDR_W-1:0] W0_addr,
  output logic [63:0]       W0_data,
  output logic [7:0]        W0_mask,
  output logic              R0_en,
  output logic [ADDR_W-1:0] R0_addr,
  input  logic [63:0]       R0_data,
  output logic              busy,
  output logic              err
);

  localparam int             c_timer_w = $clog2(TIMEOUT + 1);
  localparam logic [c_timer_w-1:0] c_timeout = c_timer_w'(TIMEOUT);
  localparam logic [7:0]     c_op_wr   = 8'h57;
  localparam logic [7:0]     c_op_rd   = 8'h52;
  localparam logic [7:0]     c_rsp_ok  = 8'h4B;
  localparam logic [7:0]     c_rsp_bad = 8'h3F;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_MASK    = 3'd2,
    S_DATA    = 3'd3,
    S_WRITE   = 3'd4,
    S_READ    = 3'd5,
    S_CAPTURE = 3'd6,
    S_SEND    = 3'd7
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic                   r_is_write;
  logic [2:0]             r_cnt;
  logic [c_timer_w-1:0]   r_timer;
  logic [ADDR_W-1:0]      r_addr;
  logic [7:0]             r_mask;
  logic [63:0]            r_data;
  logic [63:0]            r_tx_buf;
  logic [3:0]             r_tx_left;
  logic                   r_err;
  logic                   w_in_frame;
  logic                   w_timeout;
  logic                   w_is_opcode;

  // Frame-collecting states share the inter-byte idle timer.
  assign w_in_frame  = (r_state == S_ADDR) || (r_state == S_MASK) || (r_state == S_DATA);
  assign w_timeout   = (r_timer == c_timeout);
  assign w_is_opcode = (rx_data == c_op_wr) || (rx_data == c_op_rd);

  assign W0_addr = r_addr;
  assign R0_addr = r_addr;
  assign W0_data = r_data;
  assign W0_mask = r_mask;
  assign tx_data = r_tx_buf[63:56];
  assign err     = r_err;

  // State register; reset abandons any partial frame or pending response.
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  // Next-state decode and state-derived strobes.
  always_comb begin
    w_next_state = r_state;
    W0_en        = 1'b0;
    R0_en        = 1'b0;
    tx_valid     = 1'b0;
    busy         = (r_state != S_IDLE);
    unique case (r_state)
      S_IDLE: begin
        if (rx_valid) w_next_state = w_is_opcode ? S_ADDR : S_SEND;
      end
      S_ADDR: begin
        if (rx_valid) begin
          if (r_cnt == 3'd3) w_next_state = r_is_write ? S_MASK : S_READ;
        end else if (w_timeout) begin
          w_next_state = S_IDLE;
        end
      end
      S_MASK: begin
        if (rx_valid)       w_next_state = S_DATA;
        else if (w_timeout) w_next_state = S_IDLE;
      end
      S_DATA: begin
        if (rx_valid) begin
          if (r_cnt == 3'd7) w_next_state = S_WRITE;
        end else if (w_timeout) begin
          w_next_state = S_IDLE;
        end
      end
      S_WRITE: begin
        W0_en        = 1'b1;
        w_next_state = S_SEND;
      end
      S_READ: begin
        R0_en        = 1'b1;
        w_next_state = S_CAPTURE;
      end
      S_CAPTURE: begin
        w_next_state = S_SEND;
      end
      S_SEND: begin
        tx_valid = 1'b1;
        if (tx_ready && (r_tx_left == 4'd1)) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Frame assembly, response buffer, idle timer and sticky drop flag.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_is_write <= 1'b0;
      r_cnt      <= '0;
      r_timer    <= '0;
      r_addr     <= '0;
      r_mask     <= '0;
      r_data     <= '0;
      r_tx_buf   <= '0;
      r_tx_left  <= '0;
      r_err      <= 1'b0;
    end else begin
      // The timer only advances between bytes of a frame being collected.
      if (w_in_frame && !rx_valid) r_timer <= r_timer + 1'b1;
      else                         r_timer <= '0;

      // Bytes arriving while the block cannot accept them are lost.
      if (rx_valid && !w_in_frame && (r_state != S_IDLE)) r_err <= 1'b1;

      unique case (r_state)
        S_IDLE: begin
          if (rx_valid) begin
            r_is_write <= (rx_data == c_op_wr);
            r_cnt      <= '0;
            // Cleared so an ADDR_W wider than 32 never keeps stale bits.
            r_addr     <= '0;
            if (!w_is_opcode) begin
              r_tx_buf  <= {c_rsp_bad, 56'd0};
              r_tx_left <= 4'd1;
            end
          end
        end
        S_ADDR: begin
          if (rx_valid) begin
            r_addr <= ADDR_W'({r_addr, rx_data});
            r_cnt  <= r_cnt + 3'd1;
          end
        end
        S_MASK: begin
          if (rx_valid) begin
            r_mask <= rx_data;
            r_cnt  <= '0;
          end
        end
        S_DATA: begin
          if (rx_valid) begin
            r_data <= {r_data[55:0], rx_data};
            r_cnt  <= r_cnt + 3'd1;
          end
        end
        S_WRITE: begin
          r_tx_buf  <= {c_rsp_ok, 56'd0};
          r_tx_left <= 4'd1;
        end
        S_CAPTURE: begin
          r_tx_buf  <= R0_data;
          r_tx_left <= 4'd8;
        end
        S_SEND: begin
          if (tx_ready) begin
            r_tx_buf  <= {r_tx_buf[55:0], 8'd0};
            r_tx_left <= r_tx_left - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_loader
// Description : Self-checking bench for mem_port_loader using expectation
//               queues filled at stimulus time and drained by output monitors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_loader;

  localparam int ADDR_W  = 25;
  localparam int TIMEOUT = 40;

  logic              clk = 1'b0;
  logic              resetn;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              tx_ready;
  logic              W0_en;
  logic [ADDR_W-1:0] W0_addr;
  logic [63:0]       W0_data;
  logic [7:0]        W0_mask;
  logic              R0_en;
  logic [ADDR_W-1:0] R0_addr;
  logic [63:0]       R0_data = '0;
  logic              busy;
  logic              err;

  int n_compared   = 0;
  int n_mismatched = 0;
  int wr_pulses    = 0;
  int rd_pulses    = 0;

  logic [7:0]        exp_tx[$];
  logic [ADDR_W-1:0] exp_wa[$];
  logic [7:0]        exp_wm[$];
  logic [63:0]       exp_wd[$];
  logic [ADDR_W-1:0] exp_ra[$];

  logic       r_hold = 1'b0;
  logic [7:0] r_held = '0;

  mem_port_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .resetn(resetn),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .W0_en(W0_en), .W0_addr(W0_addr), .W0_data(W0_data), .W0_mask(W0_mask),
    .R0_en(R0_en), .R0_addr(R0_addr), .R0_data(R0_data),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mem_model(input logic [ADDR_W-1:0] a);
    if (a == ADDR_W'(32'h10)) return 64'hDEAD_BEEF_CAFE_F00D;
    return {32'hA5A5_0000 ^ 32'(a), 32'h5A5A_5A5A ^ 32'(a)};
  endfunction

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory model: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (R0_en) R0_data <= mem_model(R0_addr);
  end

  // Output monitors sample mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (resetn) begin
      if (tx_valid && tx_ready) begin
        if (exp_tx.size() > 0) check_val("tx_byte", 64'(tx_data), 64'(exp_tx.pop_front()));
        else                   check_val("tx_pending", 64'(exp_tx.size()), 64'd1);
      end
      if (tx_valid && !tx_ready) begin
        if (r_hold) check_val("tx_stable", 64'(tx_data), 64'(r_held));
        r_hold <= 1'b1;
        r_held <= tx_data;
      end else begin
        r_hold <= 1'b0;
      end
      if (W0_en || R0_en) check_val("wr_rd_excl", 64'(W0_en & R0_en), 64'd0);
      if (W0_en) begin
        wr_pulses <= wr_pulses + 1;
        if (exp_wa.size() > 0) begin
          check_val("w0_addr", 64'(W0_addr), 64'(exp_wa.pop_front()));
          check_val("w0_mask", 64'(W0_mask), 64'(exp_wm.pop_front()));
          check_val("w0_data", W0_data, exp_wd.pop_front());
        end else begin
          check_val("wr_pending", 64'(exp_wa.size()), 64'd1);
        end
      end
      if (R0_en) begin
        rd_pulses <= rd_pulses + 1;
        if (exp_ra.size() > 0) check_val("r0_addr", 64'(R0_addr), 64'(exp_ra.pop_front()));
        else                   check_val("rd_pending", 64'(exp_ra.size()), 64'd1);
      end
    end
  end

  // Called aligned 1 time unit after a rising edge; returns aligned the same way.
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic write_frame(input logic [31:0] a, input logic [7:0] m, input logic [63:0] d);
    logic [63:0] v;
    exp_wa.push_back(ADDR_W'(a));
    exp_wm.push_back(m);
    exp_wd.push_back(d);
    exp_tx.push_back(8'h4B);
    send_byte(8'h57);
    for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8]);
    send_byte(m);
    v = d;
    for (int i = 7; i >= 0; i--) send_byte(v[8*i +: 8]);
  endtask

  task automatic read_frame(input logic [31:0] a);
    logic [63:0] v;
    exp_ra.push_back(ADDR_W'(a));
    v = mem_model(ADDR_W'(a));
    for (int i = 7; i >= 0; i--) exp_tx.push_back(v[8*i +: 8]);
    send_byte(8'h52);
    for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8]);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && (busy || exp_tx.size() > 0); i++) begin
      @(posedge clk); #1;
    end
    check_val("idle_busy", 64'(busy), 64'd0);
    check_val("tx_drained", 64'(exp_tx.size()), 64'd0);
  endtask

  task automatic wait_tx_valid(input int budget);
    for (int i = 0; i < budget && !tx_valid; i++) begin
      @(posedge clk); #1;
    end
    check_val("tx_valid_up", 64'(tx_valid), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_busy"},     64'(busy),     64'd0);
    check_val({tag, "_err"},      64'(err),      64'd0);
    check_val({tag, "_tx_valid"}, 64'(tx_valid), 64'd0);
    check_val({tag, "_tx_data"},  64'(tx_data),  64'd0);
    check_val({tag, "_w0_en"},    64'(W0_en),    64'd0);
    check_val({tag, "_r0_en"},    64'(R0_en),    64'd0);
    check_val({tag, "_w0_addr"},  64'(W0_addr),  64'd0);
    check_val({tag, "_w0_mask"},  64'(W0_mask),  64'd0);
    check_val({tag, "_w0_data"},  W0_data,       64'd0);
  endtask

  initial begin
    int wr0;
    int rd0;
    resetn   = 1'b0;
    rx_valid = 1'b0;
    rx_data  = '0;
    tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    resetn = 1'b1;
    @(posedge clk); #1;

    // Basic write with partial mask.
    write_frame(32'h0000_0010, 8'h0F, 64'h1122_3344_5566_7788);
    wait_idle(40);
    check_val("wr_pulse_count", 64'(wr_pulses), 64'd1);

    // Read with a 20-cycle stall on the first response byte.
    tx_ready = 1'b0;
    read_frame(32'h0000_0010);
    wait_tx_valid(20);
    repeat (20) @(posedge clk);
    #1;
    check_val("stall_tx_data", 64'(tx_data), 64'hDE);
    check_val("stall_tx_valid", 64'(tx_valid), 64'd1);
    tx_ready = 1'b1;
    wait_idle(40);
    check_val("rd_pulse_count", 64'(rd_pulses), 64'd1);

    // Unknown opcode answers 0x3F without touching memory.
    exp_tx.push_back(8'h3F);
    send_byte(8'h41);
    wait_idle(20);
    check_val("bad_op_wr", 64'(wr_pulses), 64'd1);
    check_val("bad_op_rd", 64'(rd_pulses), 64'd1);

    // Zero mask still strobes; address above ADDR_W is truncated.
    write_frame(32'h1234_5678, 8'h00, 64'h0102_0408_1020_4080);
    wait_idle(40);
    check_val("mask0_pulse", 64'(wr_pulses), 64'd2);
    read_frame(32'hFFFF_FF00);
    wait_idle(40);

    // Inter-byte timeout abandons the frame silently.
    wr0 = wr_pulses;
    rd0 = rd_pulses;
    send_byte(8'h57);
    send_byte(8'h00);
    repeat (TIMEOUT - 5) @(posedge clk);
    #1;
    check_val("to_busy_before", 64'(busy), 64'd1);
    repeat (10) @(posedge clk);
    #1;
    check_val("to_busy_after", 64'(busy), 64'd0);
    check_val("to_no_write", 64'(wr_pulses), 64'(wr0));
    check_val("to_err", 64'(err), 64'd0);
    read_frame(32'h0000_0010);
    wait_idle(40);
    check_val("to_read_after", 64'(rd_pulses), 64'(rd0 + 1));

    // A byte arriving during SEND is dropped and flags err.
    tx_ready = 1'b0;
    read_frame(32'h0000_0020);
    wait_tx_valid(20);
    check_val("err_before", 64'(err), 64'd0);
    send_byte(8'h99);
    check_val("err_set", 64'(err), 64'd1);
    tx_ready = 1'b1;
    wait_idle(40);
    check_val("err_sticky", 64'(err), 64'd1);

    // Reset in the middle of the data bytes discards the frame.
    wr0 = wr_pulses;
    send_byte(8'h57);
    for (int i = 0; i < 4; i++) send_byte(8'h01);
    send_byte(8'hFF);
    for (int i = 0; i < 3; i++) send_byte(8'hAA);
    check_val("mid_data_busy", 64'(busy), 64'd1);
    resetn = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("mid_rst");
    resetn = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    check_val("mid_rst_no_write", 64'(wr_pulses), 64'(wr0));
    write_frame(32'h0000_0033, 8'hA5, 64'hFEDC_BA98_7654_3210);
    wait_idle(40);
    check_val("post_rst_write", 64'(wr_pulses), 64'(wr0 + 1));
    check_val("wr_q_empty", 64'(exp_wa.size()), 64'd0);
    check_val("rd_q_empty", 64'(exp_ra.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
`default_nettype wire
